fetch_unit: RTL

//  Program-counter register plus instruction-fetch handshake. Consumes the selected next address
//  (saidaMux1 of the PC-select mux) and requests the instruction from instruction memory.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit_pc_register.sv | 33 +++
 rtl/fetch_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM state encoding and
// default reset PC / sequential step.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus and IF/ID hand-off bus of the fetch unit.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [INST_W-1:0] imem_rdata;
  logic              if_valid;
  logic              id_ready;
  logic [INST_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  modport fetch (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ready, imem_rdata, id_ready
  );

  modport env (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ready, imem_rdata, id_ready
  );
endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter with load (priority) and sequential increment; the
// increment wraps modulo 2^ADDR_W.
module pc_register #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);

  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = load_val;
    else if (inc) pc_d = pc_plus4;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register plus instruction-fetch FSM: requests from instruction memory and
// presents {pc, instruction} to IF/ID with a valid/ready handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              pc_load,
  input  logic              stall,
  fetch_unit_if.fetch       bus,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pc_misalign
);

  fetch_state_e      state_d, state_q;
  logic              req_d, req_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              valid_d, valid_q;
  logic [INST_W-1:0] instr_d, instr_q;
  logic [ADDR_W-1:0] ifpc_d, ifpc_q;
  logic              misalign_d, misalign_q;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;

  assign target = {pc_next[ADDR_W-1:2], 2'b00};

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clock    (clock),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (target),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ifpc_q;
  assign pc_misalign   = misalign_q;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    misalign_d = pc_load & (pc_next[1:0] != 2'b00);
    pc_inc     = 1'b0;
    if (pc_load) valid_d = 1'b0;

    // addr_q only moves when no request is outstanding, so a raised request
    // keeps its address until imem_ready even across redirects (DROP).
    unique case (state_q)
      IDLE: begin
        if (pc_load || !stall) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_load ? target : pc;
        end
      end
      REQ: begin
        if (pc_load) begin
          if (bus.imem_ready) addr_d  = target;
          else                state_d = DROP;
        end else if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          ifpc_d  = addr_q;
          valid_d = 1'b1;
          pc_inc  = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (pc_load) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = target;
        end else if (!stall && bus.id_ready) begin
          valid_d = 1'b0;
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc;
        end
      end
      DROP: begin
        if (bus.imem_ready) begin
          state_d = REQ;
          addr_d  = pc_load ? target : pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      ifpc_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
